mini68k_alu: RTL and testbench

32-bit integer ALU for the mini68k core, with registered outputs. Each cycle it computes a 4-bit-selected operation on operands a and b, then registers the 32-bit result and a 68k-style condition-code vector (X N Z V C). The execute stage drives it from decoded instruction fields. Downstream logic reads result/ccr one cycle after the operands are presented.

---
 rtl/mini68k_alu.sv | 168 ++++++++++++++++
 tb/tb_mini68k_alu.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mini68k_alu.sv
// ============================================================================
// mini68k_alu : 32-bit ALU with registered result and X/N/Z/V/C flags
// Revision 1.0
// ============================================================================
`default_nettype none

module mini68k_alu (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic [4:0]  ccr
);

   localparam logic [3:0] c_ADD  = 4'b0000;
   localparam logic [3:0] c_SUB  = 4'b0001;
   localparam logic [3:0] c_AND  = 4'b0010;
   localparam logic [3:0] c_OR   = 4'b0011;
   localparam logic [3:0] c_XOR  = 4'b0100;
   localparam logic [3:0] c_NOT  = 4'b0101;
   localparam logic [3:0] c_LSL  = 4'b0110;
   localparam logic [3:0] c_LSR  = 4'b0111;
   localparam logic [3:0] c_ASR  = 4'b1000;
   localparam logic [3:0] c_ROL  = 4'b1001;
   localparam logic [3:0] c_ROR  = 4'b1010;
   localparam logic [3:0] c_NEG  = 4'b1011;
   localparam logic [3:0] c_CMP  = 4'b1100;
   localparam logic [3:0] c_MULU = 4'b1101;
   localparam logic [3:0] c_MOVE = 4'b1110;
   localparam logic [3:0] c_SWAP = 4'b1111;

   logic [31:0]        r_result;
   logic [4:0]         r_ccr;

   logic [4:0]         w_n_cnt;
   logic [5:0]         w_inv_cnt;
   logic               w_cnt_zero;
   logic [32:0]        w_sum;
   logic [32:0]        w_diff;
   logic [31:0]        w_neg;
   logic [32:0]        w_lsl;
   logic [32:0]        w_lsr;
   logic signed [32:0] w_asr;
   logic [31:0]        w_rol;
   logic [31:0]        w_ror;
   logic [31:0]        w_mul;
   logic               w_sub_v;

   logic [31:0]        w_res;
   logic               w_write;
   logic               w_x;
   logic               w_v;
   logic               w_c;

   assign w_n_cnt    = b[4:0];
   assign w_inv_cnt  = 6'd32 - {1'b0, w_n_cnt};
   assign w_cnt_zero = (w_n_cnt == 5'd0);

   assign w_sum  = {1'b0, a} + {1'b0, b};
   assign w_diff = {1'b0, a} - {1'b0, b};
   assign w_neg  = 32'd0 - a;
   assign w_sub_v = (a[31] != b[31]) && (w_diff[31] != a[31]);

   // Shifters carry one extra bit so the last bit shifted out lands in a fixed slot.
   assign w_lsl = {1'b0, a} << w_n_cnt;
   assign w_lsr = {a, 1'b0} >> w_n_cnt;
   assign w_asr = $signed({a, 1'b0}) >>> w_n_cnt;
   assign w_rol = (a << w_n_cnt) | (a >> w_inv_cnt);
   assign w_ror = (a >> w_n_cnt) | (a << w_inv_cnt);

   assign w_mul = {16'h0000, a[15:0]} * {16'h0000, b[15:0]};

   always_comb begin
      w_res   = a;
      w_write = 1'b1;
      w_x     = r_ccr[4];
      w_v     = 1'b0;
      w_c     = 1'b0;
      case (op)
         c_ADD: begin
            w_res = w_sum[31:0];
            w_c   = w_sum[32];
            w_v   = (a[31] == b[31]) && (w_sum[31] != a[31]);
            w_x   = w_sum[32];
         end
         c_SUB: begin
            w_res = w_diff[31:0];
            w_c   = w_diff[32];
            w_v   = w_sub_v;
            w_x   = w_diff[32];
         end
         c_AND: w_res = a & b;
         c_OR:  w_res = a | b;
         c_XOR: w_res = a ^ b;
         c_NOT: w_res = ~a;
         c_LSL: begin
            if (!w_cnt_zero) begin
               w_res = w_lsl[31:0];
               w_c   = w_lsl[32];
               w_x   = w_lsl[32];
            end
         end
         c_LSR: begin
            if (!w_cnt_zero) begin
               w_res = w_lsr[32:1];
               w_c   = w_lsr[0];
               w_x   = w_lsr[0];
            end
         end
         c_ASR: begin
            if (!w_cnt_zero) begin
               w_res = w_asr[32:1];
               w_c   = w_asr[0];
               w_x   = w_asr[0];
            end
         end
         c_ROL: begin
            if (!w_cnt_zero) begin
               w_res = w_rol;
               w_c   = w_rol[0];
            end
         end
         c_ROR: begin
            if (!w_cnt_zero) begin
               w_res = w_ror;
               w_c   = w_ror[31];
            end
         end
         c_NEG: begin
            w_res = w_neg;
            w_c   = (a != 32'd0);
            w_v   = (a == 32'h8000_0000);
            w_x   = (a != 32'd0);
         end
         // CMP drives N/Z from the difference but leaves the result register alone.
         c_CMP: begin
            w_res   = w_diff[31:0];
            w_write = 1'b0;
            w_c     = w_diff[32];
            w_v     = w_sub_v;
         end
         c_MULU: w_res = w_mul;
         c_MOVE: w_res = b;
         c_SWAP: w_res = {a[15:0], a[31:16]};
         default: w_res = a;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_result <= 32'h0000_0000;
         r_ccr    <= 5'b00000;
      end else begin
         if (w_write) begin
            r_result <= w_res;
         end
         r_ccr <= {w_x, w_res[31], (w_res == 32'd0), w_v, w_c};
      end
   end

   assign result = r_result;
   assign ccr    = r_ccr;

endmodule

`default_nettype wire

// File: tb/tb_mini68k_alu.sv
// ============================================================================
// tb_mini68k_alu : directed plus random checks of mini68k_alu against a model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mini68k_alu;

   logic        clk;
   logic        rst;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] result;
   logic [4:0]  ccr;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] m_result;
   logic [4:0]  m_ccr;

   mini68k_alu dut (
      .clk    (clk),
      .rst    (rst),
      .op     (op),
      .a      (a),
      .b      (b),
      .result (result),
      .ccr    (ccr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: each op written straight from its arithmetic definition.
   task automatic model(input logic r, input logic [3:0] o,
                        input logic [31:0] x, input logic [31:0] y);
      longint unsigned s;
      int              n;
      logic [31:0]     res;
      logic            keep;
      logic            xf, vf, cf;
      if (r) begin
         m_result = 32'd0;
         m_ccr    = 5'd0;
         return;
      end
      n    = int'(y % 32);
      keep = 1'b0;
      xf   = m_ccr[4];
      vf   = 1'b0;
      cf   = 1'b0;
      res  = x;
      case (o)
         4'd0: begin
            s   = longint'(x) + longint'(y);
            res = s[31:0];
            cf  = (s >= 64'h1_0000_0000);
            vf  = (x[31] == y[31]) && (res[31] != x[31]);
            xf  = cf;
         end
         4'd1, 4'd12: begin
            res = x - y;
            cf  = (x < y);
            vf  = (x[31] != y[31]) && (res[31] != x[31]);
            if (o == 4'd1) xf = cf;
            else keep = 1'b1;
         end
         4'd2: res = x & y;
         4'd3: res = x | y;
         4'd4: res = x ^ y;
         4'd5: res = ~x;
         4'd6: if (n != 0) begin res = x << n; cf = x[32-n]; xf = cf; end
         4'd7: if (n != 0) begin res = x >> n; cf = x[n-1]; xf = cf; end
         4'd8: if (n != 0) begin res = $signed(x) >>> n; cf = x[n-1]; xf = cf; end
         4'd9: if (n != 0) begin
            for (int i = 0; i < n; i++) res = {res[30:0], res[31]};
            cf = res[0];
         end
         4'd10: if (n != 0) begin
            for (int i = 0; i < n; i++) res = {res[0], res[31:1]};
            cf = res[31];
         end
         4'd11: begin
            res = 32'd0 - x;
            cf  = (x != 0);
            vf  = (x == 32'h8000_0000);
            xf  = cf;
         end
         4'd13: res = (x & 32'hFFFF) * (y & 32'hFFFF);
         4'd14: res = y;
         default: res = {x[15:0], x[31:16]};
      endcase
      m_ccr = {xf, res[31], (res == 32'd0), vf, cf};
      if (!keep) m_result = res;
   endtask

   task automatic step(input string tag, input logic r, input logic [3:0] o,
                       input logic [31:0] x, input logic [31:0] y);
      rst = r; op = o; a = x; b = y;
      model(r, o, x, y);
      @(posedge clk);
      #1;
      chk({tag, ".res"}, result, m_result);
      chk({tag, ".ccr"}, {27'd0, ccr}, {27'd0, m_ccr});
   endtask

   task automatic dstep(input string tag, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] er, input logic [4:0] ec);
      step(tag, 1'b0, o, x, y);
      chk({tag, ".res_k"}, result, er);
      chk({tag, ".ccr_k"}, {27'd0, ccr}, {27'd0, ec});
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst = 1'b1; op = 4'd0; a = 32'd0; b = 32'd0;
      m_result = 32'd0; m_ccr = 5'd0;
      step("rst0", 1'b1, 4'd0, 32'd0, 32'd0);
      step("rst1", 1'b1, 4'd0, 32'd0, 32'd0);
      chk("rst.res_k", result, 32'd0);
      chk("rst.ccr_k", {27'd0, ccr}, 32'd0);

      dstep("add1", 4'd0,  32'h10,         32'h20,         32'h30,         5'b00000);
      dstep("add2", 4'd0,  32'hFFFF_FFFF,  32'h1,          32'h0,          5'b10101);
      dstep("add3", 4'd0,  32'h7FFF_FFFF,  32'h1,          32'h8000_0000,  5'b01010);
      dstep("sub1", 4'd1,  32'h50,         32'h20,         32'h30,         5'b00000);
      dstep("sub2", 4'd1,  32'h20,         32'h50,         32'hFFFF_FFD0,  5'b11001);
      dstep("cmp",  4'd12, 32'h5,          32'h5,          32'hFFFF_FFD0,  5'b10100);
      dstep("and",  4'd2,  32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0F00_0F00,  5'b10000);
      dstep("or",   4'd3,  32'hFF00_FF00,  32'h00FF_00FF,  32'hFFFF_FFFF,  5'b11000);
      dstep("xor",  4'd4,  32'hAAAA_AAAA,  32'h5555_5555,  32'hFFFF_FFFF,  5'b11000);
      dstep("lsl1", 4'd6,  32'h1,          32'h4,          32'h10,         5'b00000);
      dstep("lsr",  4'd7,  32'h8000_0000,  32'h4,          32'h0800_0000,  5'b00000);
      dstep("asr",  4'd8,  32'h8000_0000,  32'h4,          32'hF800_0000,  5'b01000);
      dstep("lsl2", 4'd6,  32'h8000_0001,  32'h1,          32'h2,          5'b10001);
      dstep("lsl0", 4'd6,  32'h8000_0001,  32'h20,         32'h8000_0001,  5'b11000);
      dstep("lsl31",4'd6,  32'h0000_0002,  32'h1F,         32'h0,          5'b10101);
      dstep("rol",  4'd9,  32'h8000_0001,  32'h1,          32'h3,          5'b10001);
      dstep("neg",  4'd11, 32'h1,          32'h0,          32'hFFFF_FFFF,  5'b11001);
      dstep("mulu", 4'd13, 32'h1234_FFFF,  32'hABCD_0002,  32'h0001_FFFE,  5'b10000);
      dstep("swap", 4'd15, 32'h1234_5678,  32'h0,          32'h5678_1234,  5'b10000);
      dstep("move", 4'd14, 32'h1234_5678,  32'h0,          32'h0,          5'b10100);
      step("midrst", 1'b1, 4'd0, 32'h10, 32'h20);
      chk("midrst.res_k", result, 32'd0);
      chk("midrst.ccr_k", {27'd0, ccr}, 32'd0);

      for (int i = 0; i < 600; i++) begin
         logic [31:0] ra, rb;
         logic [3:0]  ro;
         ra = pick();
         rb = pick();
         ro = 4'($urandom_range(0, 15));
         if (ro >= 4'd6 && ro <= 4'd10 && $urandom_range(0, 3) == 0)
            rb = {rb[31:5], (($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31)};
         step("rand", ($urandom_range(0, 31) == 0), ro, ra, rb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
